fpro_bus_arbiter: RTL and testbench

FPRO_BUS_ARBITER -- requirements
Module: fpro_bus_arbiter

---
 rtl/fpro_bus_arbiter.sv | 159 +++++++++++++++
 tb/tb_fpro_bus_arbiter.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpro_bus_arbiter.sv
// Two-master arbiter for the FPRO bus: IDLE -> BUS -> ACK, every bus/ack output registered.
// Define FPRO_ARB_RR_EN for round-robin arbitration; the default build uses fixed priority (m0 first).
module fpro_bus_arbiter #(
    parameter int unsigned ADDR_W = 21,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              m0_req,
    input  logic              m0_wr,
    input  logic              m0_video,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wr_data,
    output logic              m0_ack,
    output logic [DATA_W-1:0] m0_rd_data,
    input  logic              m1_req,
    input  logic              m1_wr,
    input  logic              m1_video,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wr_data,
    output logic              m1_ack,
    output logic [DATA_W-1:0] m1_rd_data,
    output logic              fp_video_cs,
    output logic              fp_mmio_cs,
    output logic              fp_wr,
    output logic              fp_rd,
    output logic [ADDR_W-1:0] fp_addr,
    output logic [DATA_W-1:0] fp_wr_data,
    input  logic [DATA_W-1:0] fp_rd_data,
    output logic              grant_id
);

    typedef enum logic [1:0] {StIdle, StBus, StAck} state_e;

    state_e              state_q, state_d;
    logic                video_cs_q, video_cs_d;
    logic                mmio_cs_q, mmio_cs_d;
    logic                wr_q, wr_d;
    logic                rd_q, rd_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                grant_q, grant_d;
    logic                ack0_q, ack0_d;
    logic                ack1_q, ack1_d;
    logic [DATA_W-1:0]   rd0_q, rd0_d;
    logic [DATA_W-1:0]   rd1_q, rd1_d;

    logic                win;
    logic                sel_wr;
    logic                sel_video;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;

`ifdef FPRO_ARB_RR_EN
    // On a tie, the master that did not own the last transaction goes next.
    assign win = (m0_req && m1_req) ? ~grant_q : m1_req;
`else
    assign win = ~m0_req;
`endif

    assign sel_wr    = win ? m1_wr      : m0_wr;
    assign sel_video = win ? m1_video   : m0_video;
    assign sel_addr  = win ? m1_addr    : m0_addr;
    assign sel_wdata = win ? m1_wr_data : m0_wr_data;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        video_cs_d = 1'b0;
        mmio_cs_d  = 1'b0;
        wr_d       = 1'b0;
        rd_d       = 1'b0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        grant_d    = grant_q;
        ack0_d     = 1'b0;
        ack1_d     = 1'b0;
        rd0_d      = rd0_q;
        rd1_d      = rd1_q;
        unique case (state_q)
            StIdle: begin
                if (m0_req || m1_req) begin
                    grant_d    = win;
                    video_cs_d = sel_video;
                    mmio_cs_d  = ~sel_video;
                    wr_d       = sel_wr;
                    rd_d       = ~sel_wr;
                    addr_d     = sel_addr;
                    wdata_d    = sel_wdata;
                    state_d    = StBus;
                end
            end
            StBus: begin
                // rd_q is the latched read flag, high only during this cycle.
                if (rd_q) begin
                    if (grant_q) rd1_d = fp_rd_data;
                    else         rd0_d = fp_rd_data;
                end
                if (grant_q) ack1_d = 1'b1;
                else         ack0_d = 1'b1;
                state_d = StAck;
            end
            StAck: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            video_cs_q <= 1'b0;
            mmio_cs_q  <= 1'b0;
            wr_q       <= 1'b0;
            rd_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            grant_q    <= 1'b1;
            ack0_q     <= 1'b0;
            ack1_q     <= 1'b0;
            rd0_q      <= '0;
            rd1_q      <= '0;
        end else begin
            video_cs_q <= video_cs_d;
            mmio_cs_q  <= mmio_cs_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            grant_q    <= grant_d;
            ack0_q     <= ack0_d;
            ack1_q     <= ack1_d;
            rd0_q      <= rd0_d;
            rd1_q      <= rd1_d;
        end
    end

    assign fp_video_cs = video_cs_q;
    assign fp_mmio_cs  = mmio_cs_q;
    assign fp_wr       = wr_q;
    assign fp_rd       = rd_q;
    assign fp_addr     = addr_q;
    assign fp_wr_data  = wdata_q;
    assign grant_id    = grant_q;
    assign m0_ack      = ack0_q;
    assign m1_ack      = ack1_q;
    assign m0_rd_data  = rd0_q;
    assign m1_rd_data  = rd1_q;

endmodule

// File: tb/tb_fpro_bus_arbiter.sv
// Scoreboard bench for fpro_bus_arbiter: stimulus queues expected bus/ack events,
// a negedge monitor pops and compares them as the DUT presents strobes and acks.
module tb_fpro_bus_arbiter;

    localparam int unsigned ADDR_W = 21;
    localparam int unsigned DATA_W = 32;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              m0_req, m0_wr, m0_video;
    logic [ADDR_W-1:0] m0_addr;
    logic [DATA_W-1:0] m0_wr_data;
    logic              m0_ack;
    logic [DATA_W-1:0] m0_rd_data;
    logic              m1_req, m1_wr, m1_video;
    logic [ADDR_W-1:0] m1_addr;
    logic [DATA_W-1:0] m1_wr_data;
    logic              m1_ack;
    logic [DATA_W-1:0] m1_rd_data;
    logic              fp_video_cs, fp_mmio_cs, fp_wr, fp_rd;
    logic [ADDR_W-1:0] fp_addr;
    logic [DATA_W-1:0] fp_wr_data;
    logic [DATA_W-1:0] fp_rd_data;
    logic              grant_id;

    fpro_bus_arbiter #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .m0_req     (m0_req),
        .m0_wr      (m0_wr),
        .m0_video   (m0_video),
        .m0_addr    (m0_addr),
        .m0_wr_data (m0_wr_data),
        .m0_ack     (m0_ack),
        .m0_rd_data (m0_rd_data),
        .m1_req     (m1_req),
        .m1_wr      (m1_wr),
        .m1_video   (m1_video),
        .m1_addr    (m1_addr),
        .m1_wr_data (m1_wr_data),
        .m1_ack     (m1_ack),
        .m1_rd_data (m1_rd_data),
        .fp_video_cs(fp_video_cs),
        .fp_mmio_cs (fp_mmio_cs),
        .fp_wr      (fp_wr),
        .fp_rd      (fp_rd),
        .fp_addr    (fp_addr),
        .fp_wr_data (fp_wr_data),
        .fp_rd_data (fp_rd_data),
        .grant_id   (grant_id)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int                cyc;
        logic              video;
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } bus_exp_t;

    typedef struct {
        int                cyc;
        logic              m;
        logic [DATA_W-1:0] rd0;
        logic [DATA_W-1:0] rd1;
    } ack_exp_t;

    bus_exp_t bus_q[$];
    ack_exp_t ack_q[$];

    int tests = 0;
    int fails = 0;
    logic [DATA_W-1:0] exp_rd0 = '0;
    logic [DATA_W-1:0] exp_rd1 = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every strobe or ack the DUT shows must match the head of its queue.
    always @(negedge clk) begin
        bus_exp_t b;
        ack_exp_t a;
        if (reset_n) begin
            if (fp_video_cs || fp_mmio_cs || fp_wr || fp_rd) begin
                check("bus_expected", 64'(bus_q.size() > 0), 64'd1);
                if (bus_q.size() > 0) begin
                    b = bus_q.pop_front();
                    check("bus_cycle", 64'(cyc), 64'(b.cyc));
                    check("bus_strobes", {60'd0, fp_video_cs, fp_mmio_cs, fp_wr, fp_rd},
                          {60'd0, b.video, ~b.video, b.wr, ~b.wr});
                    check("bus_addr", 64'(fp_addr), 64'(b.addr));
                    if (b.wr) check("bus_wdata", 64'(fp_wr_data), 64'(b.data));
                end
            end
            if (m0_ack || m1_ack) begin
                check("ack_expected", 64'(ack_q.size() > 0), 64'd1);
                if (ack_q.size() > 0) begin
                    a = ack_q.pop_front();
                    check("ack_cycle", 64'(cyc), 64'(a.cyc));
                    check("ack_master", {62'd0, m1_ack, m0_ack}, a.m ? 64'd2 : 64'd1);
                    check("grant_id", 64'(grant_id), 64'(a.m));
                    check("m0_rd_data", 64'(m0_rd_data), 64'(a.rd0));
                    check("m1_rd_data", 64'(m1_rd_data), 64'(a.rd1));
                end
            end
        end
    end

    task automatic txn(input logic m, input logic wr, input logic video,
                       input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata,
                       input logic [DATA_W-1:0] rdata, input logic chg_addr);
        bus_exp_t b;
        ack_exp_t a;
        logic     got;
        @(negedge clk);
        fp_rd_data = rdata;
        if (m) begin
            m1_req = 1'b1; m1_wr = wr; m1_video = video; m1_addr = addr; m1_wr_data = wdata;
        end else begin
            m0_req = 1'b1; m0_wr = wr; m0_video = video; m0_addr = addr; m0_wr_data = wdata;
        end
        b.cyc = cyc + 1; b.video = video; b.wr = wr; b.addr = addr; b.data = wdata;
        bus_q.push_back(b);
        if (!wr) begin
            if (m) exp_rd1 = rdata;
            else   exp_rd0 = rdata;
        end
        a.cyc = cyc + 2; a.m = m; a.rd0 = exp_rd0; a.rd1 = exp_rd1;
        ack_q.push_back(a);
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            // Disturb the granted master's address while its transaction is on the bus.
            if (chg_addr && (fp_video_cs || fp_mmio_cs)) begin
                if (m) m1_addr = addr + 21'h10;
                else   m0_addr = addr + 21'h10;
            end
            got = m ? m1_ack : m0_ack;
        end
        check("ack_seen", 64'(got), 64'd1);
        if (m) m1_req = 1'b0;
        else   m0_req = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        bus_exp_t b;
        ack_exp_t a;
        int       c;
        logic     seen;

        reset_n = 1'b0;
        m0_req = 0; m0_wr = 0; m0_video = 0; m0_addr = '0; m0_wr_data = '0;
        m1_req = 0; m1_wr = 0; m1_video = 0; m1_addr = '0; m1_wr_data = '0;
        fp_rd_data = '0;

        // Reset state
        @(negedge clk);
        check("rst_strobes", {60'd0, fp_video_cs, fp_mmio_cs, fp_wr, fp_rd}, 64'd0);
        check("rst_acks", {62'd0, m1_ack, m0_ack}, 64'd0);
        check("rst_rd0", 64'(m0_rd_data), 64'd0);
        check("rst_rd1", 64'(m1_rd_data), 64'd0);
        check("rst_grant", 64'(grant_id), 64'd1);
        check("rst_addr", 64'(fp_addr), 64'd0);
        check("rst_wdata", 64'(fp_wr_data), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // Single MMIO write from m0, address disturbed mid-BUS
        txn(1'b0, 1'b1, 1'b0, 21'h00010, 32'hDEADBEEF, 32'h0, 1'b1);
        repeat (3) begin
            @(negedge clk);
            check("idle_strobes", {60'd0, fp_video_cs, fp_mmio_cs, fp_wr, fp_rd}, 64'd0);
            check("hold_addr", 64'(fp_addr), 64'h10);
            check("hold_wdata", 64'(fp_wr_data), 64'hDEADBEEF);
        end
        check("addr_disturbed", 64'(m0_addr), 64'h20);

        // Video read from m1, then MMIO read from m0, then video write from m1
        txn(1'b1, 1'b0, 1'b1, 21'h100000, 32'h0, 32'h12345678, 1'b0);
        txn(1'b0, 1'b0, 1'b0, 21'h00055, 32'h0, 32'hA5A5A5A5, 1'b0);
        txn(1'b1, 1'b1, 1'b1, 21'h1FFFFF, 32'h0BADF00D, 32'hFFFFFFFF, 1'b0);
        repeat (2) @(negedge clk);

        // Contention: both masters request continuously from reset
        reset_n = 1'b0;
        exp_rd0 = '0;
        exp_rd1 = '0;
        m0_req = 1; m0_wr = 1; m0_video = 0; m0_addr = 21'h111; m0_wr_data = 32'h1111;
        m1_req = 1; m1_wr = 1; m1_video = 1; m1_addr = 21'h222; m1_wr_data = 32'h2222;
        @(negedge clk);
        reset_n = 1'b1;
        c = cyc;
        for (int k = 0; k < 4; k++) begin
`ifdef FPRO_ARB_RR_EN
            a.m = k[0];
`else
            a.m = 1'b0;
`endif
            b.cyc = c + 1 + 3 * k;
            b.video = a.m;
            b.wr = 1'b1;
            b.addr = a.m ? 21'h222 : 21'h111;
            b.data = a.m ? 32'h2222 : 32'h1111;
            bus_q.push_back(b);
            a.cyc = c + 2 + 3 * k;
            a.rd0 = '0;
            a.rd1 = '0;
            ack_q.push_back(a);
        end
        repeat (11) @(negedge clk);
        m0_req = 1'b0;
        m1_req = 1'b0;
        repeat (5) @(negedge clk);
        check("contention_drained", 64'(ack_q.size()), 64'd0);

        // Reset in the middle of a read on the bus
        @(negedge clk);
        m0_req = 1; m0_wr = 0; m0_video = 0; m0_addr = 21'h77;
        fp_rd_data = 32'hCAFEF00D;
        b.cyc = cyc + 1; b.video = 1'b0; b.wr = 1'b0; b.addr = 21'h77; b.data = '0;
        bus_q.push_back(b);
        seen = 1'b0;
        for (int i = 0; i < 5 && !seen; i++) begin
            @(negedge clk);
            seen = fp_mmio_cs;
        end
        check("rst_mid_bus_seen", 64'(seen), 64'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_mid_strobes", {60'd0, fp_video_cs, fp_mmio_cs, fp_wr, fp_rd}, 64'd0);
        check("rst_mid_grant", 64'(grant_id), 64'd1);
        m0_req = 1'b0;
        exp_rd0 = '0;
        exp_rd1 = '0;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("rst_mid_no_ack", {62'd0, m1_ack, m0_ack}, 64'd0);
        end
        check("rst_mid_rd0", 64'(m0_rd_data), 64'd0);

        check("bus_q_empty", 64'(bus_q.size()), 64'd0);
        check("ack_q_empty", 64'(ack_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
